fwd_data_path: RTL and testbench
================================

# fwd_data_path

Operand-forwarding datapath that consumes the select codes produced by the forwarding unit and delivers the actual 32-bit values to EXE, MEM store-data and the decode-stage branch/JR comparator. It keeps a 3-deep history of results for the last three issued instructions (slots 1/2/3 = PC-4/PC-8/PC-12), aligned with the forwarding unit's write-register history. It tracks loads whose data has not yet returned and raises a load-use stall when a select points at such a slot.

## Interface
- No parameters; data width fixed at 32.
- CLK  in  1  pipeline clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- exe_result  in  32  result of the instruction leaving EXE this cycle; enters slot 1.
- exe_reg_write  in  1  that instruction writes a register.
- exe_load  in  1  that instruction is a load; its exe_result is invalid.
- mem_load_data  in  32  load return data.
- mem_load_valid  in  1  mem_load_data valid for the oldest pending load slot.
- rf_a, rf_b  in  32  register-file values for rs/rt.
- sel_a, sel_b, sel_mem, sel_br_a, sel_br_b  in  2  each: 0 = register file, 1/2/3 = slot 1/2/3.
- op_a, op_b  out  32  forwarded EXE operands.
- store_data  out  32  forwarded store data (sel_mem; 0 selects rf_b).
- br_a, br_b  out  32  forwarded branch/JR operands (0 selects rf_a/rf_b).
- load_use_stall  out  1  a selected slot is still pending.
- load_lost  out  1  sticky: a pending load left slot 3 unresolved.

## Operation
- Each slot holds data[31:0] and pend.
- Every posedge, unconditionally: slot3 <= slot2; slot2 <= slot1; slot1.data <= exe_result; slot1.pend <= exe_reg_write & exe_load.
- Load capture: if mem_load_valid, the oldest pending slot (3 before 2 before 1) gets data = mem_load_data and pend = 0, applied in the position it moves to. Only one capture per cycle.
- If slot3 is pending at an edge and not captured that edge, load_lost sets and holds until reset.
- Mux outputs are purely combinational from slot contents plus sel_*. sel = 0 selects the rf value.
- load_use_stall = OR over the five selects of (sel != 0 and selected slot pend).
- The forwarding unit guarantees that non-zero selects only point at slots whose instruction writes a register. No extra check is done here.

## Timing
- Reset (asynchronous, RESET low): all slot data = 0, pend = 0, load_lost = 0.
- Output values during reset: op_a = rf_a, op_b = rf_b, store_data = rf_b, br_a = rf_a, br_b = rf_b, load_use_stall = 0.
- Reset released mid-pending: all pending state is discarded.
- exe_result written at edge N is visible via select 1 during cycle N+1, via 2 in N+2, via 3 in N+3, then dropped.
- Selects are sampled combinationally. Zero added latency from sel to outputs.
- mem_load_valid together with a slot shift: capture targets the shifted position. Capture has priority over the load_lost check for slot3.
- Simultaneous new pending load into slot 1 and capture: the capture goes to the older slot, never to the new entry.

## Configuration
- FWD_LOAD_BYPASS_EN defined: when mem_load_valid is high, a select pointing at the oldest pending slot returns mem_load_data combinationally. That slot does not contribute to load_use_stall, saving one stall cycle.
- Undefined: the data is usable only after the capturing edge. load_use_stall stays high in the return cycle.

## Test plan
- Reset low, rf_a = 0x11, rf_b = 0x22, all sel = 0 -> op_a = 0x11, op_b = 0x22, store_data = 0x22, load_use_stall = 0, load_lost = 0.
- Push 0xA, 0xB, 0xC on consecutive edges (reg_write = 1) -> sel_a = 1/2/3 returns 0xC/0xB/0xA. One more edge -> sel_a = 3 returns 0xB.
- Push a load (exe_load = 1), sel_b = 1 next cycle -> load_use_stall = 1.
  - Without bypass: mem_load_valid = 1 with 0xDEAD -> stall still 1 that cycle; next cycle sel_b = 2 gives 0xDEAD, stall = 0.
  - With FWD_LOAD_BYPASS_EN: op_b = 0xDEAD and stall = 0 in the return cycle.
- Two back-to-back loads, a single mem_load_valid with 0x5 -> the older load gets 0x5, the younger stays pending.
- A load left unresolved for 3 edges -> load_lost = 1 after the third edge and stays 1. RESET pulse -> load_lost = 0.
- Assert RESET while slot 2 is pending and sel_br_a = 2 -> br_a = rf_a immediately and load_use_stall = 0.

Source files
------------

// File: rtl/fwd_data_path.sv
// fwd_data_path: operand-forwarding datapath.
// Holds the results of the last three issued instructions in slot 1/2/3
// (PC-4/PC-8/PC-12), tracks loads whose data has not yet returned, and muxes
// the slot values onto the EXE operands, the store data and the branch/JR
// comparator operands according to the forwarding unit's select codes.
//
// Optional feature: define FWD_LOAD_BYPASS_EN to let the load data returning
// this cycle feed the muxes directly, which removes one load-use stall cycle.
//
// Load return interface: mem_load_valid is a valid-only qualifier (no ready).
// When high, mem_load_data belongs to the oldest pending slot and is always
// accepted on that edge; a return with no pending slot is ignored.
module fwd_data_path (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] exe_result,
    input  logic        exe_reg_write,
    input  logic        exe_load,
    input  logic [31:0] mem_load_data,
    input  logic        mem_load_valid,
    input  logic [31:0] rf_a,
    input  logic [31:0] rf_b,
    input  logic [1:0]  sel_a,
    input  logic [1:0]  sel_b,
    input  logic [1:0]  sel_mem,
    input  logic [1:0]  sel_br_a,
    input  logic [1:0]  sel_br_b,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [31:0] store_data,
    output logic [31:0] br_a,
    output logic [31:0] br_b,
    output logic        load_use_stall,
    output logic        load_lost
);

    // Slot history; index 0 is unused so select codes index directly.
    logic [3:1][31:0] data_q, data_d;
    logic [3:1]       pend_q, pend_d;
    logic             lost_q, lost_d;

    logic [1:0]       oldest;     // oldest pending slot, 0 = none
    logic [3:0]       hit;        // slot served by returning load this cycle
    logic [3:0][31:0] view;       // value each select code would deliver
    logic [3:0]       pend_eff;   // pending after bypass is accounted for

    // Find the oldest pending slot: 3 before 2 before 1.
    always_comb begin
        oldest = 2'd0;
        if (pend_q[3])      oldest = 2'd3;
        else if (pend_q[2]) oldest = 2'd2;
        else if (pend_q[1]) oldest = 2'd1;
    end

    // Next slot state: unconditional shift, then at most one load capture
    // applied at the position the captured entry moves to.
    always_comb begin
        data_d[1] = exe_result;
        pend_d[1] = exe_reg_write & exe_load;
        data_d[2] = data_q[1];
        pend_d[2] = pend_q[1];
        data_d[3] = data_q[2];
        pend_d[3] = pend_q[2];
        if (mem_load_valid) begin
            case (oldest)
                2'd1: begin
                    data_d[2] = mem_load_data;
                    pend_d[2] = 1'b0;
                end
                2'd2: begin
                    data_d[3] = mem_load_data;
                    pend_d[3] = 1'b0;
                end
                default: ; // slot 3 captured as it retires, or nothing pending
            endcase
        end
        // A pending slot 3 is always the oldest, so a return this edge
        // resolves it; otherwise it retires unresolved.
        lost_d = lost_q | (pend_q[3] & ~mem_load_valid);
    end

    // Slot history and sticky lost flag; reset discards all pending state.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            data_q <= '0;
            pend_q <= '0;
            lost_q <= 1'b0;
        end else begin
            data_q <= data_d;
            pend_q <= pend_d;
            lost_q <= lost_d;
        end
    end

    // Per-select-code value and effective pending bit, including bypass.
    always_comb begin
        hit      = '0;
        view     = '0;
        pend_eff = '0;
        for (int i = 1; i <= 3; i++) begin
`ifdef FWD_LOAD_BYPASS_EN
            hit[i] = mem_load_valid && (oldest == 2'(i));
`else
            hit[i] = 1'b0;
`endif
            view[i]     = hit[i] ? mem_load_data : data_q[i];
            pend_eff[i] = pend_q[i] & ~hit[i];
        end
    end

    // Output muxes; while reset is held every output shows the rf value.
    always_comb begin
        op_a       = (!RESET || sel_a    == 2'd0) ? rf_a : view[sel_a];
        op_b       = (!RESET || sel_b    == 2'd0) ? rf_b : view[sel_b];
        store_data = (!RESET || sel_mem  == 2'd0) ? rf_b : view[sel_mem];
        br_a       = (!RESET || sel_br_a == 2'd0) ? rf_a : view[sel_br_a];
        br_b       = (!RESET || sel_br_b == 2'd0) ? rf_b : view[sel_br_b];
        load_use_stall = RESET & (pend_eff[sel_a] | pend_eff[sel_b] |
                                  pend_eff[sel_mem] | pend_eff[sel_br_a] |
                                  pend_eff[sel_br_b]);
        load_lost  = lost_q;
    end

endmodule

// File: tb/tb_fwd_data_path.sv
// Directed testbench for fwd_data_path with hand-computed expectations.
module tb_fwd_data_path;

    logic        CLK;
    logic        RESET;
    logic [31:0] exe_result;
    logic        exe_reg_write;
    logic        exe_load;
    logic [31:0] mem_load_data;
    logic        mem_load_valid;
    logic [31:0] rf_a, rf_b;
    logic [1:0]  sel_a, sel_b, sel_mem, sel_br_a, sel_br_b;
    logic [31:0] op_a, op_b, store_data, br_a, br_b;
    logic        load_use_stall, load_lost;

    int checks   = 0;
    int failures = 0;

    fwd_data_path dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .exe_result     (exe_result),
        .exe_reg_write  (exe_reg_write),
        .exe_load       (exe_load),
        .mem_load_data  (mem_load_data),
        .mem_load_valid (mem_load_valid),
        .rf_a           (rf_a),
        .rf_b           (rf_b),
        .sel_a          (sel_a),
        .sel_b          (sel_b),
        .sel_mem        (sel_mem),
        .sel_br_a       (sel_br_a),
        .sel_br_b       (sel_br_b),
        .op_a           (op_a),
        .op_b           (op_b),
        .store_data     (store_data),
        .br_a           (br_a),
        .br_b           (br_b),
        .load_use_stall (load_use_stall),
        .load_lost      (load_lost)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // One rising edge, then step clear of it before driving or sampling.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one instruction leaving EXE for the next edge.
    task automatic push(input logic [31:0] res, input logic wr, input logic ld);
        exe_result    = res;
        exe_reg_write = wr;
        exe_load      = ld;
        tick();
        exe_result    = 32'h0;
        exe_reg_write = 1'b0;
        exe_load      = 1'b0;
    endtask

    task automatic clear_sels();
        sel_a = 2'd0; sel_b = 2'd0; sel_mem = 2'd0; sel_br_a = 2'd0; sel_br_b = 2'd0;
    endtask

    initial begin
        RESET = 1'b0;
        exe_result = 32'h0; exe_reg_write = 1'b0; exe_load = 1'b0;
        mem_load_data = 32'h0; mem_load_valid = 1'b0;
        rf_a = 32'h11; rf_b = 32'h22;
        clear_sels();
        #12;

        // Reset state
        check("rst_op_a", op_a, 32'h11);
        check("rst_op_b", op_b, 32'h22);
        check("rst_store", store_data, 32'h22);
        check("rst_br_a", br_a, 32'h11);
        check("rst_br_b", br_b, 32'h22);
        check("rst_stall", {31'b0, load_use_stall}, 32'h0);
        check("rst_lost", {31'b0, load_lost}, 32'h0);

        @(negedge CLK);
        RESET = 1'b1;
        #1;

        // Result history through slots 1/2/3
        push(32'hA, 1'b1, 1'b0);
        push(32'hB, 1'b1, 1'b0);
        push(32'hC, 1'b1, 1'b0);
        sel_a = 2'd1; #1; check("hist_s1", op_a, 32'hC);
        sel_a = 2'd2; #1; check("hist_s2", op_a, 32'hB);
        sel_a = 2'd3; #1; check("hist_s3", op_a, 32'hA);
        sel_mem = 2'd3; sel_br_b = 2'd2; #1;
        check("hist_store_s3", store_data, 32'hA);
        check("hist_br_b_s2", br_b, 32'hB);
        check("hist_stall", {31'b0, load_use_stall}, 32'h0);
        clear_sels();
        push(32'h0, 1'b0, 1'b0);
        sel_a = 2'd3; #1; check("hist_shift_s3", op_a, 32'hB);
        clear_sels(); #1;

        // Load-use stall and single load return
        push(32'hBAD, 1'b1, 1'b1);
        sel_b = 2'd1; #1;
        check("ld_stall", {31'b0, load_use_stall}, 32'h1);
        mem_load_valid = 1'b1; mem_load_data = 32'hDEAD; #1;
`ifdef FWD_LOAD_BYPASS_EN
        check("ld_ret_op_b", op_b, 32'hDEAD);
        check("ld_ret_stall", {31'b0, load_use_stall}, 32'h0);
`else
        check("ld_ret_stall", {31'b0, load_use_stall}, 32'h1);
`endif
        tick();
        mem_load_valid = 1'b0;
        sel_b = 2'd2; #1;
        check("ld_after_op_b", op_b, 32'hDEAD);
        check("ld_after_stall", {31'b0, load_use_stall}, 32'h0);
        clear_sels(); #1;

        // Two back-to-back loads, one return: older gets it
        push(32'h1, 1'b1, 1'b1);   // L1
        push(32'h2, 1'b1, 1'b1);   // L2; slot1=L2, slot2=L1
        mem_load_valid = 1'b1; mem_load_data = 32'h5;
        tick();                    // L1 -> slot3 with 0x5, L2 -> slot2 pending
        mem_load_valid = 1'b0;
        sel_a = 2'd3; #1;
        check("two_old_data", op_a, 32'h5);
        check("two_old_stall", {31'b0, load_use_stall}, 32'h0);
        sel_br_a = 2'd2; #1;
        check("two_young_stall", {31'b0, load_use_stall}, 32'h1);
        clear_sels(); #1;

        // L2 left unresolved: slot3 after next edge, lost after the one after
        tick();
        check("lost_before", {31'b0, load_lost}, 32'h0);
        sel_mem = 2'd3; #1;
        check("lost_s3_stall", {31'b0, load_use_stall}, 32'h1);
        clear_sels();
        tick();
        check("lost_set", {31'b0, load_lost}, 32'h1);
        tick();
        check("lost_sticky", {31'b0, load_lost}, 32'h1);
        RESET = 1'b0; #1;
        check("lost_rst", {31'b0, load_lost}, 32'h0);
        @(negedge CLK);
        RESET = 1'b1;
        #1;

        // Reset asserted while slot 2 is pending
        push(32'h77, 1'b1, 1'b1);
        tick();
        sel_br_a = 2'd2; #1;
        check("rstpend_stall_pre", {31'b0, load_use_stall}, 32'h1);
        RESET = 1'b0; #1;
        check("rstpend_br_a", br_a, 32'h11);
        check("rstpend_stall", {31'b0, load_use_stall}, 32'h0);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("rstpend_after", {31'b0, load_use_stall}, 32'h0);
        clear_sels();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout got=0x%08h expected=0x%08h", 0, 1);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
